dot_accel: RTL and testbench
============================

# dot_accel

Avalon-MM dot-product accelerator that sits inside `dnn_accel_system`, directly upstream of the SDRAM controller. Software programs the vector pointers, length, bias and activation enable through a slave port. The block then streams weight/activation pairs from SDRAM over its master port and computes a Q16.16 multiply-accumulate. It adds the bias, optionally applies ReLU, and writes one result word back to SDRAM. One instance computes one neuron; the CPU loops over neurons.

## Interface
Parameters:
- `ADDR_W`, default 32: master byte-address width.

Ports:
- `clk` in 1: system clock; all logic is on its rising edge.
- `reset` in 1: synchronous, active-high reset. One clock; reset is synchronous and active-high.
- `slave_address` in 4: word offset of the register being accessed.
- `slave_read`, `slave_write` in 1 each: CPU access strobes.
- `slave_writedata` in 32: write data; `slave_readdata` out 32: read data.
- `slave_waitrequest` out 1: stalls the CPU.
- `master_address` out ADDR_W: byte address.
- `master_read`, `master_write` out 1 each: SDRAM access strobes.
- `master_writedata` out 32: write data.
- `master_waitrequest` in 1: SDRAM stall.
- `master_readdata` in 32: read data.
- `master_readdatavalid` in 1: read data qualifier.

## Operation
- Register offsets:
  - 0: write = start; read = last result.
  - 1: weight pointer `wptr`.
  - 2: activation pointer `aptr`.
  - 3: length `n` (32-bit unsigned).
  - 4: bias (Q16.16 signed).
  - 5: output pointer `optr`.
  - 6: ReLU enable (bit 0).
  - Offsets 7–15: writes ignored, reads return 0.
- Pointer bits [1:0] are forced to 0 on write.
- FSM states: IDLE, RD_W, WT_W, RD_A, WT_A, MAC, WR, DONE.
- IDLE → RD_W on a start write with `n` ≠ 0. With `n` = 0, IDLE → WR, and the result is the bias after optional ReLU.
- RD_W: drive `master_read`=1 and address `wptr`+4i. Go to WT_W on the first cycle `master_waitrequest`=0.
- WT_W: latch `master_readdata` when `master_readdatavalid`=1, then go to RD_A.
- RD_A / WT_A: same as RD_W / WT_W, at `aptr`+4i.
- Only one read is outstanding at any time.
- MAC: acc ← acc + product[47:16], where product = signed 32×32 → 64. Accumulation wraps mod 2^32 with no saturation. Then i ← i+1; go to RD_W if i < n, else go to WR.
- WR: result = acc + bias (wrapping). If ReLU is on and result[31]=1, result = 0. Drive `master_write`=1, address `optr`, data result. Go to DONE on the first cycle `master_waitrequest`=0.
- DONE: latch result into register 0 and clear acc and i, then return to IDLE.
- Slave accesses while the FSM is not IDLE: `slave_waitrequest`=1 until the cycle after the FSM returns to IDLE. The access then completes with normal IDLE semantics. This covers config writes, a second start, and a result read.
- Slave accesses in IDLE: `slave_waitrequest`=0. Writes take effect on the same edge; `slave_readdata` is valid in the same cycle (combinational from registers).

## Timing
- Reset values:
  - All master and slave outputs 0; `slave_waitrequest` 0.
  - All registers, acc, i and result are 0; FSM is in IDLE.
- Reset mid-operation: the outstanding read or write strobe drops at the reset edge, and any late `master_readdatavalid` is ignored.
- Master address, read/write and writedata are registered and stay stable while `master_waitrequest`=1.
- With zero waitrequest and one-cycle read latency, each element costs 5 cycles (RD_W, WT_W, RD_A, WT_A, MAC).
- Start to write accept takes 5n+1 cycles. DONE adds 1 cycle, then IDLE.
- `master_readdatavalid` outside WT_W/WT_A is ignored.

## Structure
- Package `dnn_pkg` holds:
  - the `dot_state_t` enum;
  - register offset localparams `REG_START`..`REG_RELU`;
  - `FRAC_BITS` = 16.
- Sub-module `fx_mac`: signed Q16.16 multiply with [47:16] extraction, plus wrapping accumulate.
- The FSM and register file live in `dot_accel`.

## Test plan
- Basic dot product: n=2, w={0x00010000, 0x00020000}, a={0x00030000, 0x00008000}, bias 0x00008000, ReLU off → one write of 0x00048000 to `optr`. Register 0 then reads 0x00048000.
- ReLU: n=1, w={0x00010000}, a={0xFFFE0000}, bias 0.
  - ReLU on → writes 0x00000000.
  - ReLU off → writes 0xFFFE0000.
- Zero length: n=0, bias 0x00030000 → zero reads, one write of 0x00030000 within 2 cycles of the start write.
- Stalls: `master_waitrequest` high for 5 cycles on every access, plus 3-cycle read latency → address and strobes stay stable and the result matches the unstalled run.
- Busy slave access: read offset 0 and write offset 1 issued mid-run → `slave_waitrequest` stays high until the FSM returns to IDLE. The read then returns the new result, and the write lands afterwards.
- Reset mid-operation: assert `reset` during WT_A with data pending → strobes are 0 and registers are 0 on the next cycle, no write is ever issued, and a fresh start works correctly.

Source files
------------

// File: rtl/dnn_pkg.sv
// Shared types and constants for the dot-product accelerator.
package dnn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_W,
        ST_WT_W,
        ST_RD_A,
        ST_WT_A,
        ST_MAC,
        ST_WR,
        ST_DONE
    } dot_state_t;

    localparam logic [3:0] REG_START = 4'd0;
    localparam logic [3:0] REG_WPTR  = 4'd1;
    localparam logic [3:0] REG_APTR  = 4'd2;
    localparam logic [3:0] REG_LEN   = 4'd3;
    localparam logic [3:0] REG_BIAS  = 4'd4;
    localparam logic [3:0] REG_OPTR  = 4'd5;
    localparam logic [3:0] REG_RELU  = 4'd6;

    localparam int unsigned FRAC_BITS = 16;

    // Clamp negative Q16.16 values to zero when ReLU is enabled.
    function automatic logic [31:0] apply_relu(input logic [31:0] v, input logic en);
        return (en && v[31]) ? '0 : v;
    endfunction

    // Pointers are always word aligned.
    function automatic logic [31:0] word_align(input logic [31:0] v);
        return {v[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fx_mac.sv
// Signed Q16.16 multiply with mid-word extraction and wrapping accumulate.
module fx_mac
    import dnn_pkg::*;
(
    input  logic [31:0] w,
    input  logic [31:0] a,
    input  logic [31:0] acc_in,
    output logic [31:0] acc_out
);

    logic signed [63:0] w_ext;
    logic signed [63:0] a_ext;
    logic signed [63:0] product;
    logic               unused_product_bits;

    // Full 64-bit signed product; keep bits [47:16] and add to the accumulator mod 2^32.
    always_comb begin
        w_ext               = {{32{w[31]}}, w};
        a_ext               = {{32{a[31]}}, a};
        product             = w_ext * a_ext;
        acc_out             = acc_in + product[FRAC_BITS+31:FRAC_BITS];
        unused_product_bits = ^{product[63:FRAC_BITS+32], product[FRAC_BITS-1:0]};
    end

endmodule

// File: rtl/dot_accel.sv
// Avalon-MM dot-product accelerator: register file, sequencing FSM and SDRAM master.
module dot_accel
    import dnn_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        slave_address,
    input  logic              slave_read,
    input  logic              slave_write,
    input  logic [31:0]       slave_writedata,
    output logic [31:0]       slave_readdata,
    output logic              slave_waitrequest,
    output logic [ADDR_W-1:0] master_address,
    output logic              master_read,
    output logic              master_write,
    output logic [31:0]       master_writedata,
    input  logic              master_waitrequest,
    input  logic [31:0]       master_readdata,
    input  logic              master_readdatavalid
);

    dot_state_t state_q, state_d;

    logic [31:0] wptr_q, wptr_d;
    logic [31:0] aptr_q, aptr_d;
    logic [31:0] len_q, len_d;
    logic [31:0] bias_q, bias_d;
    logic [31:0] optr_q, optr_d;
    logic        relu_q, relu_d;
    logic [31:0] result_q, result_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] idx_q, idx_d;
    logic [31:0] wval_q, wval_d;
    logic [31:0] aval_q, aval_d;

    logic [ADDR_W-1:0] maddr_q, maddr_d;
    logic              mrd_q, mrd_d;
    logic              mwr_q, mwr_d;
    logic [31:0]       mwdata_q, mwdata_d;

    logic        start;
    logic [31:0] mac_sum;

    fx_mac u_mac (
        .w       (wval_q),
        .a       (aval_q),
        .acc_in  (acc_q),
        .acc_out (mac_sum)
    );

    // Register file writes; the CPU is stalled outside IDLE so writes only land there.
    always_comb begin
        wptr_d   = wptr_q;
        aptr_d   = aptr_q;
        len_d    = len_q;
        bias_d   = bias_q;
        optr_d   = optr_q;
        relu_d   = relu_q;
        result_d = result_q;
        start    = 1'b0;
        if (state_q == ST_IDLE && slave_write) begin
            case (slave_address)
                REG_START: start  = 1'b1;
                REG_WPTR:  wptr_d = word_align(slave_writedata);
                REG_APTR:  aptr_d = word_align(slave_writedata);
                REG_LEN:   len_d  = slave_writedata;
                REG_BIAS:  bias_d = slave_writedata;
                REG_OPTR:  optr_d = word_align(slave_writedata);
                REG_RELU:  relu_d = slave_writedata[0];
                default:   ;
            endcase
        end
        if (state_q == ST_DONE) begin
            result_d = mwdata_q;
        end
    end

    // Operand capture, accumulation and element index.
    always_comb begin
        wval_d = wval_q;
        aval_d = aval_q;
        acc_d  = acc_q;
        idx_d  = idx_q;
        case (state_q)
            ST_WT_W: if (master_readdatavalid) wval_d = master_readdata;
            ST_WT_A: if (master_readdatavalid) aval_d = master_readdata;
            ST_MAC: begin
                acc_d = mac_sum;
                idx_d = idx_q + 32'd1;
            end
            ST_DONE: begin
                acc_d = '0;
                idx_d = '0;
            end
            default: ;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = (len_q == '0) ? ST_WR : ST_RD_W;
            ST_RD_W: if (!master_waitrequest) state_d = ST_WT_W;
            ST_WT_W: if (master_readdatavalid) state_d = ST_RD_A;
            ST_RD_A: if (!master_waitrequest) state_d = ST_WT_A;
            ST_WT_A: if (master_readdatavalid) state_d = ST_MAC;
            ST_MAC:  state_d = ((idx_q + 32'd1) < len_q) ? ST_RD_W : ST_WR;
            ST_WR:   if (!master_waitrequest) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Master outputs decoded from the next state so they come straight from flops
    // and hold steady while the SDRAM stalls.
    always_comb begin
        mrd_d    = 1'b0;
        mwr_d    = 1'b0;
        maddr_d  = maddr_q;
        mwdata_d = mwdata_q;
        case (state_d)
            ST_RD_W: begin
                mrd_d   = 1'b1;
                maddr_d = ADDR_W'(wptr_q + {idx_d[29:0], 2'b00});
            end
            ST_RD_A: begin
                mrd_d   = 1'b1;
                maddr_d = ADDR_W'(aptr_q + {idx_d[29:0], 2'b00});
            end
            ST_WR: begin
                mwr_d    = 1'b1;
                maddr_d  = ADDR_W'(optr_q);
                mwdata_d = apply_relu(acc_d + bias_q, relu_q);
            end
            default: ;
        endcase
    end

    // Slave side: stall any access while busy, combinational read mux.
    always_comb begin
        slave_waitrequest = (state_q != ST_IDLE) && (slave_read || slave_write);
        case (slave_address)
            REG_START: slave_readdata = result_q;
            REG_WPTR:  slave_readdata = wptr_q;
            REG_APTR:  slave_readdata = aptr_q;
            REG_LEN:   slave_readdata = len_q;
            REG_BIAS:  slave_readdata = bias_q;
            REG_OPTR:  slave_readdata = optr_q;
            REG_RELU:  slave_readdata = {31'b0, relu_q};
            default:   slave_readdata = '0;
        endcase
    end

    assign master_address   = maddr_q;
    assign master_read      = mrd_q;
    assign master_write     = mwr_q;
    assign master_writedata = mwdata_q;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath, register file and master output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q   <= '0;
            aptr_q   <= '0;
            len_q    <= '0;
            bias_q   <= '0;
            optr_q   <= '0;
            relu_q   <= 1'b0;
            result_q <= '0;
            acc_q    <= '0;
            idx_q    <= '0;
            wval_q   <= '0;
            aval_q   <= '0;
            maddr_q  <= '0;
            mrd_q    <= 1'b0;
            mwr_q    <= 1'b0;
            mwdata_q <= '0;
        end else begin
            wptr_q   <= wptr_d;
            aptr_q   <= aptr_d;
            len_q    <= len_d;
            bias_q   <= bias_d;
            optr_q   <= optr_d;
            relu_q   <= relu_d;
            result_q <= result_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            wval_q   <= wval_d;
            aval_q   <= aval_d;
            maddr_q  <= maddr_d;
            mrd_q    <= mrd_d;
            mwr_q    <= mwr_d;
            mwdata_q <= mwdata_d;
        end
    end

endmodule

// File: tb/tb_dot_accel.sv
// Bench for dot_accel: SDRAM responder with stalls/latency, access scoreboard and dot-product model.
module tb_dot_accel;
    import dnn_pkg::*;

    localparam int unsigned ADDR_W = 32;
    localparam int LIMIT = 3000;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  slave_address;
    logic        slave_read;
    logic        slave_write;
    logic [31:0] slave_writedata;
    logic [31:0] slave_readdata;
    logic        slave_waitrequest;
    logic [ADDR_W-1:0] master_address;
    logic        master_read;
    logic        master_write;
    logic [31:0] master_writedata;
    logic        master_waitrequest;
    logic [31:0] master_readdata;
    logic        master_readdatavalid;

    always #5 clk = ~clk;

    dot_accel #(.ADDR_W(ADDR_W)) dut (
        .clk                  (clk),
        .reset                (reset),
        .slave_address        (slave_address),
        .slave_read           (slave_read),
        .slave_write          (slave_write),
        .slave_writedata      (slave_writedata),
        .slave_readdata       (slave_readdata),
        .slave_waitrequest    (slave_waitrequest),
        .master_address       (master_address),
        .master_read          (master_read),
        .master_write         (master_write),
        .master_writedata     (master_writedata),
        .master_waitrequest   (master_waitrequest),
        .master_readdata      (master_readdata),
        .master_readdatavalid (master_readdatavalid)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        n_assert++;
        n_fail++;
        $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
    endtask

    // ---------------- SDRAM model and access scoreboard ----------------
    typedef struct {
        bit        wr;
        bit [31:0] addr;
        bit [31:0] data;
    } acc_t;

    bit [31:0] mem [bit [31:0]];
    acc_t      exp_q[$];

    int        cfg_stall = 0;
    int        cfg_lat   = 1;
    bit        spur_en   = 0;
    bit        pend      = 0;
    int        pend_cnt  = 0;
    bit [31:0] pend_data = '0;
    int        writes_seen = 0;
    int        wr_cycle    = 0;
    bit [31:0] last_addr   = '0;
    bit        last_wr     = 0;
    int        stall_cnt   = 0;
    bit [31:0] cap_addr, cap_data;
    bit        cap_rd, cap_wr;

    function automatic bit [31:0] mem_rd(input bit [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    // Behavioural neuron: sum of Q16.16 products, plus bias, optional ReLU.
    function automatic bit [31:0] model_dot(input int unsigned n, input bit [31:0] wp,
                                            input bit [31:0] ap, input bit [31:0] bias,
                                            input bit relu);
        bit [31:0] acc;
        bit [31:0] res;
        longint    p;
        acc = 0;
        for (int unsigned i = 0; i < n; i++) begin
            p   = longint'(int'(mem_rd(wp + 32'(4 * i)))) * longint'(int'(mem_rd(ap + 32'(4 * i))));
            acc = acc + 32'(p >>> 16);
        end
        res = acc + bias;
        if (relu && int'(res) < 0) res = 0;
        return res;
    endfunction

    initial begin : responder
        acc_t e;
        master_waitrequest   = 1'b0;
        master_readdatavalid = 1'b0;
        master_readdata      = '0;
        forever begin
            @(negedge clk);
            master_readdatavalid = 1'b0;
            master_readdata      = '0;
            if (pend) begin
                pend_cnt--;
                if (pend_cnt <= 0) begin
                    master_readdatavalid = 1'b1;
                    master_readdata      = pend_data;
                    pend                 = 0;
                end
            end else if (spur_en && $urandom_range(0, 3) == 0) begin
                master_readdatavalid = 1'b1;
                master_readdata      = $urandom;
            end
            if (master_read || master_write) begin
                if (stall_cnt == 0) begin
                    cap_addr = master_address;
                    cap_data = master_writedata;
                    cap_rd   = master_read;
                    cap_wr   = master_write;
                end else begin
                    chk("stall_addr", master_address, cap_addr);
                    chk("stall_strobes", {30'b0, master_read, master_write}, {30'b0, cap_rd, cap_wr});
                    if (cap_wr) chk("stall_wdata", master_writedata, cap_data);
                end
                if (stall_cnt < cfg_stall) begin
                    master_waitrequest = 1'b1;
                    stall_cnt++;
                end else begin
                    master_waitrequest = 1'b0;
                    stall_cnt          = 0;
                    chk("single_strobe", {31'b0, master_read & master_write}, 32'h0);
                    last_addr = master_address;
                    last_wr   = master_write;
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_access", $sformatf("got %s at 0x%08h, expected none",
                                 master_write ? "write" : "read", master_address));
                    end else begin
                        e = exp_q.pop_front();
                        chk("access_kind", {31'b0, master_write}, {31'b0, e.wr});
                        chk("access_addr", master_address, e.addr);
                        if (master_write) begin
                            chk("write_data", master_writedata, e.data);
                            writes_seen++;
                            wr_cycle = cyc + 1;
                        end else begin
                            chk("one_outstanding", {31'b0, pend}, 32'h0);
                            pend      = 1;
                            pend_cnt  = cfg_lat;
                            pend_data = mem_rd(master_address);
                        end
                    end
                end
            end else begin
                master_waitrequest = 1'b0;
                stall_cnt          = 0;
            end
        end
    end

    // ---------------- CPU-side access tasks ----------------
    task automatic slave_wr(input logic [3:0] a, input logic [31:0] d, output int waits);
        @(negedge clk);
        slave_address   = a;
        slave_writedata = d;
        slave_write     = 1'b1;
        #1;
        waits = 0;
        while (slave_waitrequest && waits < LIMIT) begin
            @(negedge clk);
            #1;
            waits++;
        end
        if (waits >= LIMIT) fail_now("slave_write_timeout", "waitrequest never dropped");
        @(posedge clk);
        #1;
        slave_write = 1'b0;
    endtask

    task automatic slave_rd(input logic [3:0] a, output logic [31:0] d, output int waits);
        @(negedge clk);
        slave_address = a;
        slave_read    = 1'b1;
        #1;
        waits = 0;
        while (slave_waitrequest && waits < LIMIT) begin
            @(negedge clk);
            #1;
            waits++;
        end
        if (waits >= LIMIT) fail_now("slave_read_timeout", "waitrequest never dropped");
        d = slave_readdata;
        @(posedge clk);
        #1;
        slave_read = 1'b0;
    endtask

    // ---------------- job control ----------------
    bit [31:0] jw [16];
    bit [31:0] ja [16];
    int        start_cyc = 0;
    int        job_ws0   = 0;
    bit [31:0] job_ap    = '0;

    task automatic start_job(input int unsigned n, input bit [31:0] wp_raw, input bit [31:0] ap_raw,
                             input bit [31:0] op_raw, input bit [31:0] bias, input bit relu,
                             output bit [31:0] exp_res);
        bit [31:0] wp, ap, op;
        int w;
        wp = {wp_raw[31:2], 2'b00};
        ap = {ap_raw[31:2], 2'b00};
        op = {op_raw[31:2], 2'b00};
        for (int unsigned i = 0; i < n; i++) begin
            mem[wp + 32'(4 * i)] = jw[i];
            mem[ap + 32'(4 * i)] = ja[i];
        end
        exp_res = model_dot(n, wp, ap, bias, relu);
        exp_q.delete();
        for (int unsigned i = 0; i < n; i++) begin
            exp_q.push_back('{1'b0, wp + 32'(4 * i), 32'h0});
            exp_q.push_back('{1'b0, ap + 32'(4 * i), 32'h0});
        end
        exp_q.push_back('{1'b1, op, exp_res});
        job_ap    = ap;
        last_addr = '0;
        slave_wr(REG_WPTR, wp_raw, w);
        slave_wr(REG_APTR, ap_raw, w);
        slave_wr(REG_LEN, n, w);
        slave_wr(REG_BIAS, bias, w);
        slave_wr(REG_OPTR, op_raw, w);
        slave_wr(REG_RELU, {31'b0, relu}, w);
        job_ws0 = writes_seen;
        slave_wr(REG_START, $urandom, w);
        start_cyc = cyc;
    endtask

    task automatic finish_job(input bit [31:0] exp_res, input int unsigned n, input bit timing);
        int k;
        int w;
        logic [31:0] d;
        k = 0;
        while (writes_seen == job_ws0 && k < LIMIT) begin
            @(negedge clk);
            k++;
        end
        if (k >= LIMIT) fail_now("result_write_timeout", "no result write issued");
        slave_rd(REG_START, d, w);
        chk("result_reg", d, exp_res);
        chk("leftover_accesses", 32'(exp_q.size()), 32'h0);
        if (timing) chk("start_to_write_cycles", 32'(wr_cycle - start_cyc), 32'(5 * n + 1));
    endtask

    initial begin
        #2_000_000;
        fail_now("watchdog", "simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        bit [31:0]   er;
        logic [31:0] d;
        int          w;
        int          ws0;
        int          k;
        bit          found;
        int unsigned n;

        reset           = 1'b1;
        slave_address   = '0;
        slave_read      = 1'b0;
        slave_write     = 1'b0;
        slave_writedata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_master_read", {31'b0, master_read}, 32'h0);
        chk("rst_master_write", {31'b0, master_write}, 32'h0);
        chk("rst_master_address", master_address, 32'h0);
        chk("rst_master_wdata", master_writedata, 32'h0);
        chk("rst_slave_wait", {31'b0, slave_waitrequest}, 32'h0);
        chk("rst_slave_rdata", slave_readdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Unmapped offsets and ReLU bit width.
        slave_wr(4'd9, 32'hDEADBEEF, w);
        slave_rd(4'd9, d, w);
        chk("unmapped_read", d, 32'h0);
        slave_wr(REG_RELU, 32'hFFFF_FFFF, w);
        slave_rd(REG_RELU, d, w);
        chk("relu_reg_bit0", d, 32'h1);

        // Basic dot product; pointer low bits must be dropped.
        jw[0] = 32'h0001_0000; jw[1] = 32'h0002_0000;
        ja[0] = 32'h0003_0000; ja[1] = 32'h0000_8000;
        start_job(2, 32'h0000_1003, 32'h0000_2001, 32'h0000_3002, 32'h0000_8000, 1'b0, er);
        chk("model_basic", er, 32'h0004_8000);
        finish_job(er, 2, 1'b1);
        slave_rd(REG_WPTR, d, w);
        chk("wptr_aligned", d, 32'h0000_1000);
        slave_rd(REG_OPTR, d, w);
        chk("optr_aligned", d, 32'h0000_3000);

        // ReLU on and off with a negative product.
        jw[0] = 32'h0001_0000; ja[0] = 32'hFFFE_0000;
        start_job(1, 32'h0000_1100, 32'h0000_2100, 32'h0000_3100, 32'h0, 1'b1, er);
        chk("model_relu_on", er, 32'h0000_0000);
        finish_job(er, 1, 1'b1);
        start_job(1, 32'h0000_1100, 32'h0000_2100, 32'h0000_3104, 32'h0, 1'b0, er);
        chk("model_relu_off", er, 32'hFFFE_0000);
        finish_job(er, 1, 1'b1);

        // Zero length: bias only, single write one cycle after start.
        start_job(0, 32'h0000_1200, 32'h0000_2200, 32'h0000_3200, 32'h0003_0000, 1'b0, er);
        chk("model_zero_len", er, 32'h0003_0000);
        finish_job(er, 0, 1'b1);

        // Stalled bus and long read latency: same answer as the basic run.
        cfg_stall = 5;
        cfg_lat   = 3;
        jw[0] = 32'h0001_0000; jw[1] = 32'h0002_0000;
        ja[0] = 32'h0003_0000; ja[1] = 32'h0000_8000;
        start_job(2, 32'h0000_1300, 32'h0000_2300, 32'h0000_3300, 32'h0000_8000, 1'b0, er);
        chk("model_stalled", er, 32'h0004_8000);
        finish_job(er, 2, 1'b0);
        cfg_stall = 0;
        cfg_lat   = 1;

        // Busy result read: stalls until the job ends, then returns the new result.
        for (int i = 0; i < 3; i++) begin jw[i] = $urandom; ja[i] = $urandom; end
        start_job(3, 32'h0000_4000, 32'h0000_4100, 32'h0000_4200, $urandom, 1'b0, er);
        repeat (3) @(negedge clk);
        slave_rd(REG_START, d, w);
        chk("busy_read_result", d, er);
        chk("busy_read_stalled", {31'b0, w > 0}, 32'h1);
        chk("busy_read_after_write", 32'(writes_seen - job_ws0), 32'h1);
        chk("busy_read_no_leftover", 32'(exp_q.size()), 32'h0);

        // Busy config write: lands only after the job, job uses the old pointer.
        for (int i = 0; i < 2; i++) begin jw[i] = $urandom; ja[i] = $urandom; end
        start_job(2, 32'h0000_4400, 32'h0000_4500, 32'h0000_4600, $urandom, 1'b1, er);
        repeat (2) @(negedge clk);
        slave_wr(REG_WPTR, 32'h0000_5004, w);
        chk("busy_write_stalled", {31'b0, w > 0}, 32'h1);
        chk("busy_write_after_job", 32'(writes_seen - job_ws0), 32'h1);
        chk("busy_write_no_leftover", 32'(exp_q.size()), 32'h0);
        slave_rd(REG_WPTR, d, w);
        chk("busy_write_landed", d, 32'h0000_5004);
        slave_rd(REG_START, d, w);
        chk("busy_write_result", d, er);

        // Randomized jobs with stalls, latency and spurious readdatavalid.
        spur_en = 1;
        for (int j = 0; j < 6; j++) begin
            n = $urandom_range(1, 8);
            for (int unsigned i = 0; i < n; i++) begin jw[i] = $urandom; ja[i] = $urandom; end
            cfg_stall = $urandom_range(0, 3);
            cfg_lat   = $urandom_range(1, 3);
            start_job(n, 32'h0001_0000 + 32'(j * 256) + 32'($urandom_range(0, 3)),
                      32'h0002_0000 + 32'(j * 256) + 32'($urandom_range(0, 3)),
                      32'h0003_0000 + 32'(j * 16) + 32'($urandom_range(0, 3)),
                      $urandom, 1'($urandom_range(0, 1)), er);
            finish_job(er, n, (cfg_stall == 0 && cfg_lat == 1));
        end
        spur_en   = 0;
        cfg_stall = 0;
        cfg_lat   = 3;

        // Reset while waiting for activation data.
        jw[0] = $urandom; jw[1] = $urandom; ja[0] = $urandom; ja[1] = $urandom;
        start_job(2, 32'h0000_6000, 32'h0000_6100, 32'h0000_6200, 32'h1234_5678, 1'b0, er);
        found = 0;
        k     = 0;
        while (!found && k < 200) begin
            @(negedge clk);
            #2;
            found = pend && !last_wr && (last_addr == job_ap);
            k++;
        end
        chk("reached_wt_a", {31'b0, found}, 32'h1);
        ws0   = writes_seen;
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        chk("midrst_master_read", {31'b0, master_read}, 32'h0);
        chk("midrst_master_write", {31'b0, master_write}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        for (int r = 0; r < 7; r++) begin
            slave_rd(4'(r), d, w);
            chk($sformatf("midrst_reg%0d", r), d, 32'h0);
        end
        repeat (8) @(negedge clk);
        chk("midrst_no_write", 32'(writes_seen), 32'(ws0));
        chk("midrst_read_drained", {31'b0, pend}, 32'h0);

        // Fresh start after reset.
        cfg_lat = 1;
        jw[0] = 32'h0001_0000; jw[1] = 32'h0002_0000;
        ja[0] = 32'h0003_0000; ja[1] = 32'h0000_8000;
        start_job(2, 32'h0000_7000, 32'h0000_7100, 32'h0000_7200, 32'h0000_8000, 1'b0, er);
        chk("model_after_reset", er, 32'h0004_8000);
        finish_job(er, 2, 1'b1);

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
